// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding instruction memory read, one-deep hold toward decode.
// Define FETCH_STATS_EN to build the fetchCount accepted-instruction counter.
module fetch_unit #(
   parameter int ADDR_WIDTH  = 12,
   parameter int INSTR_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  pcIn,
   output logic                   pcIncEn,
   input  logic                   stall,
   input  logic                   flush,
   output logic [ADDR_WIDTH-1:0]  memAddr,
   output logic                   memReq,
   input  logic                   memAck,
   input  logic [INSTR_WIDTH-1:0] memData,
   output logic [INSTR_WIDTH-1:0] instrOut,
   output logic                   instrValid,
   input  logic                   instrReady,
   output logic [15:0]            fetchCount
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   valid_q, valid_d;

   always_comb begin
      // NOTE: every _d gets its hold value first so no branch can leave one unassigned (latch).
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (!flush && !stall) begin
               state_d = ST_FETCH;
               addr_d  = pcIn;
            end
         end
         ST_FETCH: begin
            if (memAck && !flush) begin
               state_d = ST_HOLD;
               instr_d = memData;
               valid_d = 1'b1;
            end else if (memAck) begin
               state_d = ST_IDLE;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            // A flushed instruction is dropped whether or not decode is ready this cycle.
            if (flush) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (instrReady) begin
               valid_d = 1'b0;
               if (!stall) begin
                  state_d = ST_FETCH;
                  addr_d  = pcIn;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            if (memAck) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign memReq     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign pcIncEn    = (state_q == ST_FETCH) && memAck && !flush;
   assign memAddr    = addr_q;
   assign instrOut   = instr_q;
   assign instrValid = valid_q;

`ifdef FETCH_STATS_EN
   logic [15:0] count_q;

   always_ff @(posedge clock) begin
      if (rst)          count_q <= '0;
      else if (pcIncEn) count_q <= count_q + 16'd1;
   end

   assign fetchCount = count_q;
`else
   assign fetchCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model. Works with or without FETCH_STATS_EN defined.
module tb_fetch_unit;

   logic        clock;
   logic        rst;
   logic [11:0] pcIn;
   logic        pcIncEn;
   logic        stall;
   logic        flush;
   logic [11:0] memAddr;
   logic        memReq;
   logic        memAck;
   logic [15:0] memData;
   logic [15:0] instrOut;
   logic        instrValid;
   logic        instrReady;
   logic [15:0] fetchCount;

   int n_tests = 0;
   int n_fail  = 0;
   int inc_count = 0;
   int base_inc;

   // Environment: the upstream PC register (load on pc_set/flush, else increment on pcIncEn).
   logic [11:0] pc_q = '0;
   logic [11:0] target = '0;
   logic        pc_set = 1'b0;

   assign pcIn = pc_q;

   fetch_unit #(.ADDR_WIDTH(12), .INSTR_WIDTH(16)) dut (
      .clock      (clock),
      .rst        (rst),
      .pcIn       (pcIn),
      .pcIncEn    (pcIncEn),
      .stall      (stall),
      .flush      (flush),
      .memAddr    (memAddr),
      .memReq     (memReq),
      .memAck     (memAck),
      .memData    (memData),
      .instrOut   (instrOut),
      .instrValid (instrValid),
      .instrReady (instrReady),
      .fetchCount (fetchCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pc_set || flush) pc_q <= target;
      else if (pcIncEn)    pc_q <= pc_q + 12'd1;
      if (pcIncEn) inc_count <= inc_count + 1;
   end

   function automatic logic [15:0] mem_word(input logic [11:0] a);
      return {a[3:0], a} ^ 16'h5A5A;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic restart(input logic [11:0] pc);
      rst = 1'b1; pc_set = 1'b1; target = pc;
      stall = 1'b1; flush = 1'b0; memAck = 1'b0; instrReady = 1'b0; memData = '0;
      @(posedge clock);
      @(posedge clock);
      #1;
      rst = 1'b0; pc_set = 1'b0;
   endtask

   task automatic test_reset();
      restart(12'h010);
      n_tests++;
      if ({memAddr, memReq, instrOut, instrValid, fetchCount, pcIncEn} !== 47'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got addr=%h req=%b instr=%h valid=%b cnt=%h inc=%b want all 0",
                  memAddr, memReq, instrOut, instrValid, fetchCount, pcIncEn);
      end
   endtask

   task automatic test_fetch_basic();
      base_inc = inc_count;
      stall = 1'b0;
      tick();
      n_tests++;
      if ({memReq, memAddr} !== {1'b1, 12'h010}) begin
         n_fail++; $display("FAIL basic_issue got req=%b addr=%h want req=1 addr=010", memReq, memAddr);
      end
      #2;
      n_tests++;
      if (pcIncEn !== 1'b0) begin
         n_fail++; $display("FAIL basic_noack_inc got %b want 0", pcIncEn);
      end
      tick();
      memAck = 1'b1; memData = 16'hA5C3;
      #2;
      n_tests++;
      if (pcIncEn !== 1'b1) begin
         n_fail++; $display("FAIL basic_ack_inc got %b want 1", pcIncEn);
      end
      tick();
      memAck = 1'b0;
      n_tests++;
      if ({instrValid, instrOut, memReq} !== {1'b1, 16'hA5C3, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_hold got valid=%b instr=%h req=%b want valid=1 instr=a5c3 req=0",
                  instrValid, instrOut, memReq);
      end
      n_tests++;
      if (pcIn !== 12'h011 || inc_count - base_inc != 1) begin
         n_fail++; $display("FAIL basic_pc got pc=%h pulses=%0d want pc=011 pulses=1", pcIn, inc_count - base_inc);
      end
   endtask

   task automatic test_hold_stable();
      instrReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #2;
         n_tests++;
         if ({instrValid, instrOut, memReq, pcIncEn} !== {1'b1, 16'hA5C3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_stable[%0d] got valid=%b instr=%h req=%b inc=%b want 1 a5c3 0 0",
                     i, instrValid, instrOut, memReq, pcIncEn);
         end
         tick();
      end
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
      n_tests++;
      if ({memAddr, memReq, instrValid} !== {12'h011, 1'b1, 1'b0} || inc_count - base_inc != 1) begin
         n_fail++;
         $display("FAIL hold_next_fetch got addr=%h req=%b valid=%b pulses=%0d want 011 1 0 1",
                  memAddr, memReq, instrValid, inc_count - base_inc);
      end
   endtask

   task automatic test_flush_drain();
      restart(12'h100);
      base_inc = inc_count;
      stall = 1'b0;
      tick();
      flush = 1'b1; target = 12'h200;
      #2;
      n_tests++;
      if (pcIncEn !== 1'b0) begin
         n_fail++; $display("FAIL drain_flush_inc got %b want 0", pcIncEn);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         flush = (i == 0);
         #2;
         n_tests++;
         if (memReq !== 1'b1) begin
            n_fail++; $display("FAIL drain_req[%0d] got %b want 1", i, memReq);
         end
         tick();
      end
      flush = 1'b0; memAck = 1'b1; memData = 16'hDEAD;
      #2;
      n_tests++;
      if (pcIncEn !== 1'b0) begin
         n_fail++; $display("FAIL drain_ack_inc got %b want 0", pcIncEn);
      end
      tick();
      memAck = 1'b0;
      n_tests++;
      if ({memReq, instrValid} !== 2'b00) begin
         n_fail++; $display("FAIL drain_idle got req=%b valid=%b want 0 0", memReq, instrValid);
      end
      tick();
      n_tests++;
      if ({memAddr, memReq, instrValid} !== {12'h200, 1'b1, 1'b0} || inc_count != base_inc) begin
         n_fail++;
         $display("FAIL drain_refetch got addr=%h req=%b valid=%b pulses=%0d want 200 1 0 0",
                  memAddr, memReq, instrValid, inc_count - base_inc);
      end
   endtask

   task automatic test_flush_ack();
      restart(12'h300);
      stall = 1'b0;
      tick();
      memAck = 1'b1; flush = 1'b1; target = 12'h040; memData = 16'h1234;
      #2;
      n_tests++;
      if (pcIncEn !== 1'b0) begin
         n_fail++; $display("FAIL flushack_inc got %b want 0", pcIncEn);
      end
      tick();
      memAck = 1'b0; flush = 1'b0;
      n_tests++;
      if ({instrValid, memReq} !== 2'b00) begin
         n_fail++; $display("FAIL flushack_idle got valid=%b req=%b want 0 0", instrValid, memReq);
      end
      tick();
      n_tests++;
      if ({memAddr, memReq} !== {12'h040, 1'b1}) begin
         n_fail++; $display("FAIL flushack_newpc got addr=%h req=%b want 040 1", memAddr, memReq);
      end
      memAck = 1'b1; memData = 16'h4321;
      tick();
      memAck = 1'b0;
      n_tests++;
      if ({instrValid, instrOut} !== {1'b1, 16'h4321}) begin
         n_fail++; $display("FAIL flushhold_valid got valid=%b instr=%h want 1 4321", instrValid, instrOut);
      end
      flush = 1'b1; instrReady = 1'b1; target = 12'h060;
      tick();
      flush = 1'b0; instrReady = 1'b0;
      n_tests++;
      if ({instrValid, memReq, pcIn} !== {1'b0, 1'b0, 12'h060}) begin
         n_fail++;
         $display("FAIL flushhold_drop got valid=%b req=%b pc=%h want 0 0 060", instrValid, memReq, pcIn);
      end
   endtask

   task automatic test_stall();
      restart(12'h050);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (memReq !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle[%0d] got req=%b want 0", i, memReq);
         end
         tick();
      end
      stall = 1'b0;
      tick();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if ({memReq, memAddr} !== {1'b1, 12'h050}) begin
            n_fail++; $display("FAIL stall_fetch[%0d] got req=%b addr=%h want 1 050", i, memReq, memAddr);
         end
         tick();
      end
      memAck = 1'b1; memData = 16'h0F0F;
      tick();
      memAck = 1'b0;
      n_tests++;
      if ({instrValid, instrOut} !== {1'b1, 16'h0F0F}) begin
         n_fail++; $display("FAIL stall_hold got valid=%b instr=%h want 1 0f0f", instrValid, instrOut);
      end
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({memReq, instrValid} !== 2'b00) begin
            n_fail++; $display("FAIL stall_norestart[%0d] got req=%b valid=%b want 0 0", i, memReq, instrValid);
         end
         tick();
      end
      stall = 1'b0;
      tick();
      n_tests++;
      if ({memReq, memAddr} !== {1'b1, 12'h051}) begin
         n_fail++; $display("FAIL stall_resume got req=%b addr=%h want 1 051", memReq, memAddr);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_cnt;
      restart(12'hFFE);
      base_inc = inc_count;
      stall = 1'b0; instrReady = 1'b1; memAck = 1'b1;
      for (int i = 0; i < 20; i++) begin
         memData = mem_word(memAddr);
         tick();
      end
      memData = mem_word(memAddr);
      n_tests++;
      if (inc_count - base_inc != 10) begin
         n_fail++; $display("FAIL b2b_rate got pulses=%0d want 10", inc_count - base_inc);
      end
      n_tests++;
      if ({instrValid, instrOut} !== {1'b1, mem_word(12'h007)}) begin
         n_fail++;
         $display("FAIL b2b_wrap got valid=%b instr=%h want 1 %h", instrValid, instrOut, mem_word(12'h007));
      end
`ifdef FETCH_STATS_EN
      exp_cnt = 16'd10;
`else
      exp_cnt = 16'd0;
`endif
      n_tests++;
      if (fetchCount !== exp_cnt) begin
         n_fail++; $display("FAIL b2b_count got %h want %h", fetchCount, exp_cnt);
      end
      memAck = 1'b0; instrReady = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      restart(12'h0AB);
      stall = 1'b0;
      tick();
      n_tests++;
      if (memReq !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_req got %b want 1", memReq);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; stall = 1'b1;
      n_tests++;
      if ({memAddr, memReq, instrOut, instrValid, fetchCount, pcIncEn} !== 47'h0) begin
         n_fail++;
         $display("FAIL rstmid_outputs got addr=%h req=%b instr=%h valid=%b cnt=%h inc=%b want all 0",
                  memAddr, memReq, instrOut, instrValid, fetchCount, pcIncEn);
      end
   endtask

   // Transaction-level model: one outstanding request (live or being drained) and one held word.
   task automatic test_random();
      bit          m_req, m_live, m_hold, exp_inc;
      logic [11:0] m_addr;
      logic [15:0] m_word, m_cnt, exp_fc;
      restart(12'($urandom));
      m_req = 0; m_live = 0; m_hold = 0; m_addr = '0; m_word = '0; m_cnt = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         stall      = ($urandom_range(0, 99) < 25);
         flush      = ($urandom_range(0, 99) < 8);
         target     = 12'($urandom);
         instrReady = ($urandom_range(0, 99) < 50);
         memAck     = ($urandom_range(0, 99) < 40);
         memData    = mem_word(memAddr);
         #2;
         exp_inc = m_req && m_live && memAck && !flush;
`ifdef FETCH_STATS_EN
         exp_fc = m_cnt;
`else
         exp_fc = 16'h0;
`endif
         n_tests++;
         if (memReq !== m_req || (m_req && memAddr !== m_addr) || instrValid !== m_hold ||
             (m_hold && instrOut !== m_word) || pcIncEn !== exp_inc || fetchCount !== exp_fc) begin
            n_fail++;
            $display("FAIL random[%0d] got req=%b addr=%h valid=%b instr=%h inc=%b cnt=%h want req=%b addr=%h valid=%b instr=%h inc=%b cnt=%h",
                     cyc, memReq, memAddr, instrValid, instrOut, pcIncEn, fetchCount,
                     m_req, m_addr, m_hold, m_word, exp_inc, exp_fc);
         end
         if (exp_inc) m_cnt = m_cnt + 16'd1;
         if (m_req) begin
            if (memAck) begin
               if (m_live && !flush) begin
                  m_hold = 1; m_word = mem_word(m_addr);
               end
               m_req = 0; m_live = 0;
            end else if (flush) begin
               m_live = 0;
            end
         end else if (m_hold) begin
            if (flush) begin
               m_hold = 0;
            end else if (instrReady) begin
               m_hold = 0;
               if (!stall) begin
                  m_req = 1; m_live = 1; m_addr = pcIn;
               end
            end
         end else if (!flush && !stall) begin
            m_req = 1; m_live = 1; m_addr = pcIn;
         end
         tick();
      end
      flush = 1'b0; memAck = 1'b0; instrReady = 1'b0; stall = 1'b1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b1; flush = 1'b0; memAck = 1'b0; memData = '0; instrReady = 1'b0;
      test_reset();
      test_fetch_basic();
      test_hold_stable();
      test_flush_drain();
      test_flush_ack();
      test_stall();
      test_back_to_back();
      test_reset_mid_fetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly downstream of the incrementing program-counter register.
- Consumes the PC value, issues a single-outstanding read to instruction memory, and holds the returned word for decode.
- Drives the PC's increment enable on every accepted fetch, and discards in-flight fetches on a branch flush.

Parameters:
ADDR_WIDTH, 12, width of PC / memory address
INSTR_WIDTH, 16, width of instruction word

Ports:
clock  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
pcIn  input  ADDR_WIDTH  current PC value (PC register dataOut)
pcIncEn  output  1  increment enable to PC register
stall  input  1  inhibits starting a new fetch
flush  input  1  branch/jump taken; PC reloaded this cycle
memAddr  output  ADDR_WIDTH  instruction memory address
memReq  output  1  read request, held until memAck
memAck  input  1  memory read data valid this cycle
memData  input  INSTR_WIDTH  instruction memory read data
instrOut  output  INSTR_WIDTH  fetched instruction to decode
instrValid  output  1  instrOut holds a valid instruction
instrReady  input  1  decode accepts instrOut this cycle
fetchCount  output  16  fetched-instruction counter (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high; ports named clock and rst.
- Reset:
  - state=IDLE.
  - memAddr=0, memReq=0, instrOut=0, instrValid=0, fetchCount=0.
  - pcIncEn=0.
  - Reset mid-FETCH abandons the request; memory must tolerate a dropped memReq.
- States: IDLE, FETCH, HOLD, DRAIN. Priority: rst > flush > normal.
- IDLE:
  - if !flush && !stall -> FETCH; memAddr<=pcIn at that edge.
- FETCH:
  - memReq=1; memAddr held stable.
  - memAck && !flush -> HOLD; instrOut<=memData; instrValid<=1.
  - memAck && flush -> IDLE; data discarded.
  - !memAck && flush -> DRAIN.
  - otherwise stay.
- pcIncEn:
  - Combinational: pcIncEn = (state==FETCH) && memAck && !flush.
  - Exactly one pulse per accepted instruction.
  - The PC increments at the same edge HOLD is entered, so pcIn is already PC+1 in HOLD.
- HOLD:
  - instrValid=1; instrOut stable until the handshake.
  - instrReady && !flush:
    - if !stall -> FETCH; memAddr<=pcIn; instrValid<=0.
    - else -> IDLE; instrValid<=0.
  - flush -> IDLE; instrValid<=0 regardless of instrReady. A flushed instruction is never considered consumed.
- DRAIN:
  - memReq=1 until memAck; then -> IDLE; data discarded; no pcIncEn.
  - flush in DRAIN is ignored (remains DRAIN).
- Stall:
  - Only blocks IDLE->FETCH and HOLD->FETCH.
  - Never aborts an outstanding request or drops a held instruction.
- Throughput and latency:
  - Peak throughput is 1 instruction / 2 cycles (FETCH with same-cycle ack, HOLD with same-cycle ready).
  - Address-to-instrValid latency = memory latency + 1 cycle.
- Address width: memAddr is pcIn verbatim; the PC wraps at 2^ADDR_WIDTH, and this block adds no wrap logic.
- Flush timing:
  - The PC is reloaded at the flush edge.
  - The following IDLE cycle samples the new pcIn.
  - The first post-flush fetch is issued no earlier than 1 cycle after flush.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - fetchCount increments by 1 on every cycle pcIncEn=1.
  - 16-bit, wraps 0xFFFF->0x0000.
  - Cleared by rst; not affected by flush.
- Undefined: fetchCount constantly 0; no counter logic synthesized.

Test Plan:
- Reset then pcIn=0x010, memAck 1 cycle after memReq, instrReady=1 -> memAddr=0x010, single pcIncEn pulse, instrValid with memData=0xA5C3, next fetch at 0x011.
- instrReady held 0 for 5 cycles in HOLD -> instrOut stable at 0xA5C3, instrValid=1, memReq=0, no further pcIncEn.
- flush asserted in FETCH before memAck (ack 3 cycles later) -> DRAIN, memReq held until ack, data dropped, no pcIncEn, next fetch uses new pcIn=0x200.
- flush coincident with memAck -> pcIncEn=0, instrValid stays 0, IDLE; flush in HOLD with instrReady=1 -> instrValid=0 next cycle.
- stall=1 in IDLE for 4 cycles -> memReq stays 0; stall in FETCH -> request completes, HOLD entered, FETCH not restarted until stall=0.
- FETCH_STATS_EN defined, 0x10002 fetches -> fetchCount=0x0002; rst asserted mid-FETCH -> all outputs 0 next cycle.
